// File: rtl/seg_pkg.sv
// Shared constants for the 4-digit multiplexed hex display path.
// Used by seg_scan_mux and the downstream hex-to-7-segment decoder top.
package seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = 2;
    localparam int NIB_W      = 4;
    localparam int DISP_W     = NUM_DIGITS * NIB_W;

    // Digit select during the anti-ghosting gap: every digit driver off.
    localparam logic [NUM_DIGITS-1:0] DIGIT_EN_GAP = 4'b0000;
    // Digit select / blank values presented straight out of reset.
    localparam logic [NUM_DIGITS-1:0] DIGIT_EN_RST = 4'b0001;
    localparam logic                  BLANK_OFF    = 1'b0;
    localparam logic [DISP_W-1:0]     DISP_RESET   = '0;

    // Scan phase: showing a digit, or the one-cycle gap after a tick.
    typedef enum logic {
        PH_SHOW = 1'b0,
        PH_GAP  = 1'b1
    } phase_e;

    // One-hot digit select for a digit index; bit n drives digit n.
    function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [IDX_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/seg_scan_tick.sv
// Digit-slot prescaler: counts 0..CLK_DIV-1 and asserts tick while the
// count sits at its last value, then wraps to 0.
module seg_scan_tick #(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int              CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_MAX);

    // Next count: wrap on the terminal value, otherwise increment.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    // Prescaler register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Four-digit hex display scanner. Steps a digit index on every prescaler
// tick, inserts a one-cycle all-off gap on each digit change, and presents
// the selected nibble to the downstream hex-to-7-segment decoder.
// A new value is staged in a pending register and only promoted to the
// display register on the frame wrap, so a frame is never torn.
// Optional build macro SEG_SCAN_BLANK_EN enables leading-zero blanking.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DISP_W-1:0]     value,
    input  logic                  load,
    output logic [NIB_W-1:0]      hex,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  blank,
    output logic                  frame_done
);

    logic tick;

    seg_scan_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    logic [IDX_W-1:0]      idx_q,        idx_d;
    phase_e                phase_q,      phase_d;
    logic [DISP_W-1:0]     display_q,    display_d;
    logic [DISP_W-1:0]     pending_q,    pending_d;
    logic                  pend_vld_q,   pend_vld_d;
    logic [NIB_W-1:0]      hex_q,        hex_d;
    logic [NUM_DIGITS-1:0] digit_en_q,   digit_en_d;
    logic                  frame_done_q, frame_done_d;

    logic wrap;
    assign wrap = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));

`ifdef SEG_SCAN_BLANK_EN
    logic blank_q, blank_d;
    logic lead_zero;

    // Digit n is a leading zero when it and every higher digit are zero.
    always_comb begin
        lead_zero = 1'b0;
        case (idx_q)
            2'd1:    lead_zero = (display_q[15:4]  == '0);
            2'd2:    lead_zero = (display_q[15:8]  == '0);
            2'd3:    lead_zero = (display_q[15:12] == '0);
            default: lead_zero = 1'b0;
        endcase
    end
`endif

    // Next-state: pending capture, frame-wrap swap, index step and output staging.
    always_comb begin
        idx_d        = idx_q;
        phase_d      = phase_q;
        display_d    = display_q;
        pending_d    = pending_q;
        pend_vld_d   = pend_vld_q;
        hex_d        = hex_q;
        digit_en_d   = digit_en_q;
        frame_done_d = 1'b0;
`ifdef SEG_SCAN_BLANK_EN
        blank_d      = blank_q;
`endif

        // Gap cycle over: light the digit the index now points at.
        if (phase_q == PH_GAP) begin
            phase_d    = PH_SHOW;
            digit_en_d = digit_onehot(idx_q);
            hex_d      = display_q[{idx_q, 2'b00} +: NIB_W];
`ifdef SEG_SCAN_BLANK_EN
            blank_d    = lead_zero;
`endif
        end

        // Swap uses the pending value from before any same-cycle load.
        if (wrap && pend_vld_q) begin
            display_d  = pending_q;
            pend_vld_d = 1'b0;
        end

        if (load) begin
            pending_d  = value;
            pend_vld_d = 1'b1;
        end

        if (tick) begin
            idx_d        = idx_q + IDX_W'(1);
            phase_d      = PH_GAP;
            digit_en_d   = DIGIT_EN_GAP;
            frame_done_d = wrap;
        end
    end

    // State and registered outputs; reset wins over load and tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q        <= '0;
            phase_q      <= PH_SHOW;
            display_q    <= DISP_RESET;
            pending_q    <= DISP_RESET;
            pend_vld_q   <= 1'b0;
            hex_q        <= '0;
            digit_en_q   <= DIGIT_EN_RST;
            frame_done_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            phase_q      <= phase_d;
            display_q    <= display_d;
            pending_q    <= pending_d;
            pend_vld_q   <= pend_vld_d;
            hex_q        <= hex_d;
            digit_en_q   <= digit_en_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef SEG_SCAN_BLANK_EN
    // Blank flag follows the digit select update.
    always_ff @(posedge clk) begin
        if (rst) blank_q <= BLANK_OFF;
        else     blank_q <= blank_d;
    end

    assign blank = blank_q;
`else
    assign blank = BLANK_OFF;
`endif

    assign hex        = hex_q;
    assign digit_en   = digit_en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux at CLK_DIV=4. The reference model tracks time
// since reset as a plain cycle count k: slot = k/D, index = slot mod 4,
// and the gap cycle is the first cycle of every slot after the first.
// The display/pending registers are modelled as frame-level variables.
module tb_seg_scan_mux;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic [3:0]  hex;
    logic [3:0]  digit_en;
    logic        blank;
    logic        frame_done;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          k;
    logic [15:0] m_disp, m_pend;
    bit          m_pvld;

    seg_scan_mux #(.CLK_DIV(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .load       (load),
        .hex        (hex),
        .digit_en   (digit_en),
        .blank      (blank),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s k=%0d got=%h want=%h", tag, k, act, exp);
        end
    endtask

    // Advance the model across one clock edge with the inputs that edge sees.
    task automatic model_edge(input bit r, input bit l, input logic [15:0] v);
        bit tk, wr;
        if (r) begin
            k = 0; m_disp = 16'h0; m_pend = 16'h0; m_pvld = 0;
        end else begin
            tk = (k % D) == D - 1;
            wr = tk && ((k / D) % 4) == 3;
            if (wr && m_pvld) begin
                m_disp = m_pend;
                m_pvld = 0;
            end
            if (l) begin
                m_pend = v;
                m_pvld = 1;
            end
            k++;
        end
    endtask

    // Compare DUT outputs to what the cycle count k implies.
    task automatic check_outputs();
        int  idx;
        bit  gap;
        logic [3:0]  e_en;
        logic [15:0] hi;
        bit  e_blank;
        idx = (k / D) % 4;
        gap = (k >= D) && (k % D == 0);
        e_en = gap ? 4'b0000 : (4'b0001 << idx);
        chk("digit_en", {12'h0, digit_en}, {12'h0, e_en});
        chk("frame_done", {15'h0, frame_done}, {15'h0, gap && idx == 0});
        if (!gap) begin
            chk("hex", {12'h0, hex}, {12'h0, 4'(m_disp >> (4 * idx))});
`ifdef SEG_SCAN_BLANK_EN
            hi = m_disp >> (4 * idx);
            e_blank = (idx != 0) && (hi == 16'h0);
`else
            hi = 16'h0;
            e_blank = 1'b0;
`endif
            chk("blank", {15'h0, blank}, {15'h0, e_blank});
        end
    endtask

    task automatic step(input bit r, input bit l, input logic [15:0] v);
        rst = r; load = l; value = v;
        @(posedge clk);
        model_edge(r, l, v);
        #1;
        check_outputs();
        rst = 1'b0; load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, $urandom);
    endtask

    // Idle until the next edge will close the cycle with the given k mod (4*D).
    task automatic idle_until(input int phase);
        for (int i = 0; i < 4 * D && (k % (4 * D)) != phase; i++) step(0, 0, $urandom);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = 16'h0;
        k = 0; m_disp = 0; m_pend = 0; m_pvld = 0;

        // Reset for two cycles, then watch the first slot, gap and digit 1.
        step(1, 0, 16'h0);
        step(1, 1, 16'hFFFF);
        idle(2 * D);

        // Scan a known value across full frames.
        step(0, 1, 16'h1A2F);
        idle(8 * D);

        // Mid-frame load while ABCD is displayed must not tear the frame.
        step(0, 1, 16'hABCD);
        idle(8 * D);
        idle_until(2 * D + 1);
        step(0, 1, 16'h1234);
        idle(8 * D);

        // Load on the wrap tick with another value already pending.
        idle_until(D + 1);
        step(0, 1, 16'h7777);
        idle_until(4 * D - 1);
        step(0, 1, 16'h5555);
        idle(8 * D);

        // Leading-zero patterns.
        step(0, 1, 16'h0040);
        idle(8 * D);
        step(0, 1, 16'h0000);
        idle(8 * D);
        step(0, 1, 16'h0305);
        idle(8 * D);

        // Reset during digit 2's slot, and during a gap cycle.
        step(0, 1, 16'h9876);
        idle(8 * D);
        idle_until(2 * D + 2);
        step(1, 1, 16'h4321);
        idle(6 * D);
        idle_until(3 * D);
        step(1, 0, 16'h0);
        idle(6 * D);

        // Randomised loads and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 250) == 0, ($urandom % 9) == 0,
                 (($urandom % 3) == 0) ? 16'($urandom % 16 << (4 * ($urandom % 4))) : 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
